elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_pkg.sv | 14 +
 rtl/tick_timer.sv | 37 +++
 rtl/elevator_scheduler.sv | 164 ++++++++++++++++
 tb/tb_elevator_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared state codes and floor sizing for the elevator scheduler.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 8;
    localparam int FLOOR_W        = $clog2(NUM_FLOORS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_DOOR = 2'b11
    } state_t;

endpackage

// File: rtl/tick_timer.sv
// Tick-enabled counter with a parameterised terminal count.
// done pulses combinationally on the terminal tick; clear zeroes the count next edge.
module tick_timer #(
    parameter int TERMINAL = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign done = tick && (cnt_q == W'(TERMINAL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = done ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car scheduler: latches floor calls, sweeps in the last direction, times travel and door.
// Calls reach destination one cycle after assertion; no backpressure, every call is accepted.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int TRAVEL_TICKS = 16,
    parameter int DOOR_TICKS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] destination,
    output logic [1:0]            sim_state,
    output logic                  door_open
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [NUM_FLOORS-1:0]   dest_q, dest_d;
    logic [NUM_FLOORS-1:0]   clr_mask;
    logic                    door_q;
    logic                    dir_up_q, dir_up_d;

    logic                    moving;
    logic                    state_chg;
    logic                    travel_done;
    logic                    door_done;
    logic                    door_call;
    logic                    door_exp;
    logic                    any_above, any_below;
    logic                    nf_above, nf_below;
    logic [FLOOR_W-1:0]      nf;

    assign moving    = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign door_call = (state_q == ST_DOOR) && call_req[floor_q];
    // A repeat call on the terminal tick keeps the door open rather than closing it.
    assign door_exp  = door_done && !door_call;
    assign state_chg = (state_d != state_q);

    tick_timer #(.TERMINAL(TRAVEL_TICKS)) u_travel (
        .clk   (clk),
        .rst   (rst),
        .clear (state_chg),
        .tick  (tick && moving),
        .done  (travel_done)
    );

    tick_timer #(.TERMINAL(DOOR_TICKS)) u_door (
        .clk   (clk),
        .rst   (rst),
        .clear (state_chg || door_call),
        .tick  (tick && (state_q == ST_DOOR)),
        .done  (door_done)
    );

    always_comb begin
        nf = (state_q == ST_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
        any_above = 1'b0;
        any_below = 1'b0;
        nf_above  = 1'b0;
        nf_below  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i > int'(floor_q))) any_above = 1'b1;
            if (pending_q[i] && (i < int'(floor_q))) any_below = 1'b1;
            if (pending_q[i] && (i > int'(nf)))      nf_above  = 1'b1;
            if (pending_q[i] && (i < int'(nf)))      nf_below  = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        clr_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d = ST_DOOR;
                end else if (any_above) begin
                    state_d  = ST_UP;
                    dir_up_d = 1'b1;
                end else if (any_below) begin
                    state_d  = ST_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            ST_UP: begin
                if (travel_done && (floor_q < TOP_FLOOR)) begin
                    floor_d = nf;
                    if (pending_q[nf]) begin
                        clr_mask[nf] = 1'b1;
                        state_d      = ST_DOOR;
                    end else if (!nf_above) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DOWN: begin
                if (travel_done && (floor_q != '0)) begin
                    floor_d = nf;
                    if (pending_q[nf]) begin
                        clr_mask[nf] = 1'b1;
                        state_d      = ST_DOOR;
                    end else if (!nf_below) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                clr_mask[floor_q] = 1'b1;
                if (door_exp) begin
                    if (dir_up_q ? any_above : any_below) begin
                        state_d = dir_up_q ? ST_UP : ST_DOWN;
                    end else if (dir_up_q ? any_below : any_above) begin
                        state_d  = dir_up_q ? ST_DOWN : ST_UP;
                        dir_up_d = !dir_up_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A call for the floor the car is parked at is served, not displayed as a destination.
    always_comb begin
        pending_d = (pending_q | call_req) & ~clr_mask;
        dest_d    = pending_d;
        if ((state_d == ST_IDLE) || (state_d == ST_DOOR)) begin
            dest_d = pending_d & ~(NUM_FLOORS'(1) << floor_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            dest_q    <= '0;
            door_q    <= 1'b0;
            dir_up_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            floor_q   <= tick ? floor_d : floor_q;
            pending_q <= pending_d;
            dest_q    <= dest_d;
            door_q    <= (state_d == ST_DOOR);
            dir_up_q  <= dir_up_d;
        end
    end

    assign current_floor = floor_q;
    assign destination   = dest_q;
    assign sim_state     = state_q;
    assign door_open     = door_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed and random-stress bench for elevator_scheduler with 8 floors, travel 4, door 3.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic [7:0] call_req = 8'h00;
    logic [2:0] cur_floor;
    logic [7:0] dest;
    logic [1:0] sim_state;
    logic       door_open;

    int checks   = 0;
    int failures = 0;

    elevator_scheduler #(
        .NUM_FLOORS   (8),
        .TRAVEL_TICKS (4),
        .DOOR_TICKS   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .call_req      (call_req),
        .current_floor (cur_floor),
        .destination   (dest),
        .sim_state     (sim_state),
        .door_open     (door_open)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n = 0;
        while (sim_state !== s && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, sim_state, s);
    endtask

    initial begin
        int prev_floor;
        int last_chg;
        int delta;

        // reset
        step(2);
        check_eq("rst_floor", cur_floor, 0);
        check_eq("rst_dest", dest, 8'h00);
        check_eq("rst_state", sim_state, 2'b00);
        check_eq("rst_door", door_open, 0);
        rst = 1'b0;

        // single call to floor 3
        call_req = 8'h08;
        step();
        check_eq("s1_dest_latch", dest, 8'h08);
        check_eq("s1_still_idle", sim_state, 2'b00);
        call_req = 8'h00;
        step();
        check_eq("s1_up", sim_state, 2'b01);
        step(3);
        check_eq("s1_floor0_hold", cur_floor, 0);
        step();
        check_eq("s1_floor1", cur_floor, 1);
        step(4);
        check_eq("s1_floor2", cur_floor, 2);
        step(4);
        check_eq("s1_floor3", cur_floor, 3);
        check_eq("s1_door_state", sim_state, 2'b11);
        check_eq("s1_door_open", door_open, 1);
        check_eq("s1_dest_clear", dest, 8'h00);
        step(2);
        check_eq("s1_door_last", sim_state, 2'b11);
        step();
        check_eq("s1_idle", sim_state, 2'b00);
        check_eq("s1_door_closed", door_open, 0);

        // continue up to 7, then reverse to 0
        call_req = 8'h80;
        step();
        check_eq("s2_dest80", dest, 8'h80);
        call_req = 8'h00;
        step();
        check_eq("s2_up", sim_state, 2'b01);
        call_req = 8'h01;
        step();
        check_eq("s2_dest81", dest, 8'h81);
        call_req = 8'h00;
        step(15);
        check_eq("s2_floor7", cur_floor, 7);
        check_eq("s2_door7", sim_state, 2'b11);
        check_eq("s2_dest01", dest, 8'h01);
        step(3);
        check_eq("s2_reverse", sim_state, 2'b10);
        step(4);
        check_eq("s2_floor6", cur_floor, 6);
        step(24);
        check_eq("s2_floor0", cur_floor, 0);
        check_eq("s2_door0", sim_state, 2'b11);
        check_eq("s2_dest_empty", dest, 8'h00);
        step(3);
        check_eq("s2_idle", sim_state, 2'b00);

        // call at the parked floor, then a repeat mid-door
        call_req = 8'h01;
        step();
        check_eq("s3_dest_hidden_a", dest[0], 0);
        call_req = 8'h00;
        step();
        check_eq("s3_door", sim_state, 2'b11);
        check_eq("s3_dest_hidden_b", dest[0], 0);
        step();
        check_eq("s3_dest_hidden_c", dest[0], 0);
        call_req = 8'h01;
        step();
        check_eq("s3_door_restart", sim_state, 2'b11);
        check_eq("s3_dest_hidden_d", dest[0], 0);
        call_req = 8'h00;
        step();
        check_eq("s3_door_extended1", sim_state, 2'b11);
        step();
        check_eq("s3_door_extended2", sim_state, 2'b11);
        step();
        check_eq("s3_idle", sim_state, 2'b00);
        check_eq("s3_dest_final", dest, 8'h00);

        // tick frozen mid-travel
        call_req = 8'h04;
        step();
        call_req = 8'h00;
        step();
        check_eq("s4_up", sim_state, 2'b01);
        step(2);
        tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            call_req = (i == 0) ? 8'h40 : 8'h00;
            step();
            check_eq("s4_frozen_floor", cur_floor, 0);
            check_eq("s4_frozen_state", sim_state, 2'b01);
        end
        check_eq("s4_dest_latched", dest, 8'h44);
        tick = 1'b1;
        step();
        check_eq("s4_resume_hold", cur_floor, 0);
        step();
        check_eq("s4_resume_floor1", cur_floor, 1);
        wait_state(2'b11, 40, "s4_door2_timeout");
        check_eq("s4_floor2", cur_floor, 2);
        check_eq("s4_dest40", dest, 8'h40);
        wait_state(2'b00, 100, "s4_idle_timeout");
        check_eq("s4_floor6", cur_floor, 6);
        check_eq("s4_dest_empty", dest, 8'h00);

        // reset mid-MOVING_DOWN
        call_req = 8'h3C;
        step();
        call_req = 8'h00;
        step();
        check_eq("s5_down", sim_state, 2'b10);
        check_eq("s5_dest3c", dest, 8'h3C);
        step();
        rst = 1'b1;
        call_req = 8'hFF;
        step();
        check_eq("s5_rst_floor", cur_floor, 0);
        check_eq("s5_rst_dest", dest, 8'h00);
        check_eq("s5_rst_state", sim_state, 2'b00);
        check_eq("s5_rst_door", door_open, 0);
        rst = 1'b0;
        call_req = 8'h00;
        step(3);
        check_eq("s5_post_state", sim_state, 2'b00);
        check_eq("s5_post_dest", dest, 8'h00);

        // random stress
        prev_floor = int'(cur_floor);
        last_chg   = -100;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            call_req = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            tick     = ($urandom_range(0, 3) != 0);
            step();
            check_eq("stress_door_vs_state", door_open, (sim_state == 2'b11));
            delta = int'(cur_floor) - prev_floor;
            if (delta != 0) begin
                check_eq("stress_step_size", (delta == 1 || delta == -1), 1);
                check_eq("stress_step_gap", ((cyc - last_chg) >= 4), 1);
                last_chg = cyc;
            end
            prev_floor = int'(cur_floor);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
